// File: rtl/dp_grant_ctrl.sv
// Two-channel grant controller around the external dual priority encoder.
// Masks in-service requesters from the encoder and times each grant on channels A/B.

module dp_grant_chan #(
  parameter int SVC_CYCLES = 4,
  parameter int NREQ       = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            grant,
  input  logic [3:0]      code,
  output logic            idle,
  output logic            vld,
  output logic [3:0]      id,
  output logic            done,
  output logic [NREQ-1:0] mask
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0]      SVC  = 4'(SVC_CYCLES);
  localparam logic [NREQ-1:0] ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n, id_n;
  logic            vld_n, done_n;
  logic [NREQ-1:0] mask_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      vld   <= 1'b0;
      id    <= '0;
      done  <= 1'b0;
      mask  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      vld   <= vld_n;
      id    <= id_n;
      done  <= done_n;
      mask  <= mask_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    vld_n   = vld;
    id_n    = id;
    done_n  = 1'b0;
    mask_n  = mask;
    if (state == IDLE) begin
      if (grant) begin
        state_n = BUSY;
        vld_n   = 1'b1;
        id_n    = code;
        cnt_n   = SVC;
        mask_n  = ONE << (code - 4'd1);
      end
    end else begin
      if (cnt > 4'd1) begin
        cnt_n = cnt - 4'd1;
      end else begin
        // last service cycle: release the requester and pulse done
        state_n = IDLE;
        vld_n   = 1'b0;
        cnt_n   = '0;
        done_n  = 1'b1;
        mask_n  = '0;
      end
    end
  end

  assign idle = (state == IDLE);
endmodule

module dp_grant_ctrl #(
  parameter int SVC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] req_in,
  output logic [11:0] enc_req,
  input  logic [3:0]  first,
  input  logic [3:0]  second,
  output logic        gnt_a_vld,
  output logic [3:0]  gnt_a_id,
  output logic        gnt_b_vld,
  output logic [3:0]  gnt_b_id,
  output logic        done_a,
  output logic        done_b,
  output logic [11:0] busy_mask
);
  localparam int NUM_LANES = 2;
  localparam int NREQ      = 12;
  localparam int CW        = 4;

  logic [NUM_LANES-1:0]           idle, grant, vld, done;
  logic [NUM_LANES-1:0][CW-1:0]   code, id;
  logic [NUM_LANES-1:0][NREQ-1:0] mask;

  function automatic logic code_ok(input logic [CW-1:0] c);
    return (c != '0) && (c <= 4'(NREQ));
  endfunction

  // B only sees 'second' when A is also free; otherwise the free channel takes 'first'.
  always_comb begin
    code[0] = first;
    code[1] = idle[0] ? second : first;
    for (int i = 0; i < NUM_LANES; i++)
      grant[i] = idle[i] && code_ok(code[i]);
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NUM_LANES; i++)
      busy_mask = busy_mask | mask[i];
  end

  assign enc_req = req_in & ~busy_mask;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_chan
    dp_grant_chan #(.SVC_CYCLES(SVC_CYCLES), .NREQ(NREQ)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .grant (grant[g]),
      .code  (code[g]),
      .idle  (idle[g]),
      .vld   (vld[g]),
      .id    (id[g]),
      .done  (done[g]),
      .mask  (mask[g])
    );
  end

  assign gnt_a_vld = vld[0];
  assign gnt_a_id  = id[0];
  assign done_a    = done[0];
  assign gnt_b_vld = vld[1];
  assign gnt_b_id  = id[1];
  assign done_b    = done[1];
endmodule

// File: tb/tb_dp_grant_ctrl.sv
// Scoreboard bench for dp_grant_ctrl: expected grant/done events and cycle snapshots
// are queued by the stimulus and checked by an independent negedge monitor.

module tb_dp_grant_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] req_in = '0;
  logic [11:0] enc_req, busy_mask;
  logic [3:0]  first, second, enc_first, enc_second;
  logic        ovr = 1'b0;
  logic [3:0]  ovr_first = '0, ovr_second = '0;
  logic        gnt_a_vld, gnt_b_vld, done_a, done_b;
  logic [3:0]  gnt_a_id, gnt_b_id;

  dp_grant_ctrl #(.SVC_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .enc_req(enc_req),
    .first(first), .second(second),
    .gnt_a_vld(gnt_a_vld), .gnt_a_id(gnt_a_id),
    .gnt_b_vld(gnt_b_vld), .gnt_b_id(gnt_b_id),
    .done_a(done_a), .done_b(done_b), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  // dual priority encoder model: highest and next-highest set bit, index+1
  function automatic logic [7:0] enc(input logic [11:0] r);
    logic [3:0] f, s;
    f = '0; s = '0;
    for (int i = 0; i < 12; i++)
      if (r[i]) begin s = f; f = 4'(i + 1); end
    return {f, s};
  endfunction

  always_comb begin
    {enc_first, enc_second} = enc(enc_req);
    first  = ovr ? ovr_first  : enc_first;
    second = ovr ? ovr_second : enc_second;
  end

  typedef struct { int cyc; bit kind; logic [3:0] id; } ev_t;  // kind 0 grant, 1 done
  typedef struct { int cyc; int sel; logic [11:0] val; } snap_t;
  localparam int S_BUSY = 0, S_ENC = 1, S_AVLD = 2, S_BVLD = 3, S_AID = 4, S_BID = 5;

  ev_t   qa[$], qb[$];
  snap_t qs[$];
  int    cyc = 0;
  int    n_cmp = 0, n_bad = 0;
  logic  pa = 1'b0, pb = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic exp_ev(input int ch, input bit kind, input logic [3:0] id, input int c);
    ev_t e;
    e.cyc = c; e.kind = kind; e.id = id;
    if (ch == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  task automatic exp_snap(input int c, input int sel, input logic [11:0] val);
    snap_t s;
    s.cyc = c; s.sel = sel; s.val = val;
    qs.push_back(s);
  endtask

  task automatic pop_cmp(input int ch, input bit kind, input logic [3:0] id);
    ev_t e;
    bit  have;
    have = (ch == 0) ? (qa.size() > 0) : (qb.size() > 0);
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL ev_ch%0d: got unexpected kind=%0d id=%0d at cyc %0d, want none", ch, kind, id, cyc);
      return;
    end
    e = (ch == 0) ? qa.pop_front() : qb.pop_front();
    if (e.kind != kind || e.id !== id || e.cyc != cyc) begin
      n_bad++;
      $display("FAIL ev_ch%0d: got kind=%0d id=%0d cyc=%0d, want kind=%0d id=%0d cyc=%0d",
               ch, kind, id, cyc, e.kind, e.id, e.cyc);
    end
  endtask

  function automatic logic [11:0] probe(input int sel);
    case (sel)
      S_BUSY:  return busy_mask;
      S_ENC:   return enc_req;
      S_AVLD:  return {11'b0, gnt_a_vld};
      S_BVLD:  return {11'b0, gnt_b_vld};
      S_AID:   return {8'b0, gnt_a_id};
      default: return {8'b0, gnt_b_id};
    endcase
  endfunction

  always @(negedge clk) begin
    if (gnt_a_vld && !pa) pop_cmp(0, 1'b0, gnt_a_id);
    if (done_a)           pop_cmp(0, 1'b1, gnt_a_id);
    if (gnt_b_vld && !pb) pop_cmp(1, 1'b0, gnt_b_id);
    if (done_b)           pop_cmp(1, 1'b1, gnt_b_id);
    while (qs.size() > 0 && qs[0].cyc <= cyc) begin
      snap_t s;
      s = qs.pop_front();
      chk($sformatf("snap_sel%0d_c%0d", s.sel, s.cyc), probe(s.sel), s.val);
    end
    pa <= gnt_a_vld;
    pb <= gnt_b_vld;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_clear(input string tag, input logic [11:0] exp_enc);
    chk({tag, "_a_vld"}, {11'b0, gnt_a_vld}, 12'h0);
    chk({tag, "_b_vld"}, {11'b0, gnt_b_vld}, 12'h0);
    chk({tag, "_done"},  {10'b0, done_a, done_b}, 12'h0);
    chk({tag, "_busy"},  busy_mask, 12'h000);
    chk({tag, "_enc"},   enc_req, exp_enc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    // reset with all requests up
    rst_n = 1'b0; req_in = 12'hFFF;
    #3;
    chk_all_clear("rst", 12'hFFF);
    step(2); c = cyc;
    rst_n = 1'b1;
    exp_ev(0, 0, 4'd12, c + 1); exp_ev(1, 0, 4'd11, c + 1);
    exp_ev(0, 1, 4'd12, c + 5); exp_ev(1, 1, 4'd11, c + 5);
    exp_snap(c + 1, S_BUSY, 12'hC00);
    exp_snap(c + 5, S_BUSY, 12'h000);
    step(1); req_in = '0;
    step(6);

    // dual grant, vld spans exactly 4 cycles
    c = cyc; req_in = 12'hC00;
    exp_ev(0, 0, 4'd12, c + 1); exp_ev(1, 0, 4'd11, c + 1);
    exp_ev(0, 1, 4'd12, c + 5); exp_ev(1, 1, 4'd11, c + 5);
    exp_snap(c + 1, S_BUSY, 12'hC00);
    exp_snap(c + 1, S_ENC,  12'h000);
    exp_snap(c + 4, S_AVLD, 12'h001);
    exp_snap(c + 4, S_BVLD, 12'h001);
    exp_snap(c + 5, S_AVLD, 12'h000);
    exp_snap(c + 5, S_BVLD, 12'h000);
    exp_snap(c + 5, S_BUSY, 12'h000);
    step(2); req_in = '0;
    step(5);

    // only B free: B takes first from the masked vector
    c = cyc; req_in = 12'h800;
    exp_ev(0, 0, 4'd12, c + 1);
    step(1); req_in = 12'h801;
    exp_ev(1, 0, 4'd1, c + 2);
    exp_ev(0, 1, 4'd12, c + 5);
    exp_ev(1, 1, 4'd1, c + 6);
    exp_snap(c + 1, S_ENC,  12'h001);
    exp_snap(c + 2, S_BUSY, 12'h801);
    exp_snap(c + 2, S_AID,  12'h00C);
    exp_snap(c + 2, S_BID,  12'h001);
    exp_snap(c + 3, S_AVLD, 12'h001);
    exp_snap(c + 6, S_BUSY, 12'h000);
    step(1); req_in = '0;
    step(6);

    // invalid codes never grant
    c = cyc; ovr = 1'b1; ovr_first = 4'd13; ovr_second = 4'd15; req_in = 12'hFFF;
    exp_snap(c + 1, S_BUSY, 12'h000);
    exp_snap(c + 2, S_AVLD, 12'h000);
    exp_snap(c + 2, S_BVLD, 12'h000);
    step(2); ovr_first = 4'd0; ovr_second = 4'd14;
    exp_snap(c + 3, S_BUSY, 12'h000);
    exp_snap(c + 3, S_AVLD, 12'h000);
    step(1); ovr = 1'b0; req_in = '0;
    step(2);

    // reset in the middle of service: no done afterwards
    c = cyc; req_in = 12'hC00;
    exp_ev(0, 0, 4'd12, c + 1); exp_ev(1, 0, 4'd11, c + 1);
    step(1); req_in = '0;
    step(1); #2;
    rst_n = 1'b0;
    #1;
    chk_all_clear("midrst", 12'h000);
    step(1); rst_n = 1'b1;
    exp_snap(cyc + 3, S_BUSY, 12'h000);
    exp_snap(cyc + 3, S_AVLD, 12'h000);
    step(7);

    // held request re-grants on A every 5 cycles; B never picks it up
    c = cyc; req_in = 12'h001;
    exp_ev(0, 0, 4'd1, c + 1);
    exp_ev(0, 1, 4'd1, c + 5);
    exp_ev(0, 0, 4'd1, c + 6);
    exp_ev(0, 1, 4'd1, c + 10);
    exp_snap(c + 3, S_BVLD, 12'h000);
    exp_snap(c + 5, S_BUSY, 12'h000);
    exp_snap(c + 7, S_BUSY, 12'h001);
    exp_snap(c + 8, S_BVLD, 12'h000);
    exp_snap(c + 8, S_AVLD, 12'h001);
    step(6); req_in = '0;
    step(7);

    // anything still queued was never observed
    foreach (qa[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL ev_ch0: got nothing, want kind=%0d id=%0d cyc=%0d", qa[i].kind, qa[i].id, qa[i].cyc);
    end
    foreach (qb[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL ev_ch1: got nothing, want kind=%0d id=%0d cyc=%0d", qb[i].kind, qb[i].id, qb[i].cyc);
    end
    foreach (qs[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL snap_sel%0d: got nothing, want %h at cyc %0d", qs[i].sel, qs[i].val, qs[i].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
